// File: rtl/lcd_pattern_gen.sv
// LCD test-pattern generator: eight colour modes on a 2-stage pipeline,
// with mode, frame counter and bouncing-box state updated on VSYNC falls.
module lcd_pattern_gen #(
   parameter int XW         = 11,
   parameter int YW         = 11,
   parameter int H_ACTIVE   = 480,
   parameter int V_ACTIVE   = 272,
   parameter int R_W        = 5,
   parameter int G_W        = 6,
   parameter int B_W        = 5,
   parameter int CHECK_LOG2 = 5,
   parameter int BAR_LOG2   = 6,
   parameter int GRAD_SHIFT = 3,
   parameter int BOX_SIZE   = 32
) (
   input  logic           PIXEL_CLK,
   input  logic           RESET,
   input  logic [2:0]     MODE,
   input  logic           HSYNC_IN,
   input  logic           VSYNC_IN,
   input  logic           DEN_IN,
   input  logic [XW-1:0]  XPOS,
   input  logic [YW-1:0]  YPOS,
   output logic           HSYNC,
   output logic           VSYNC,
   output logic           DEN,
   output logic [R_W-1:0] LCD_R,
   output logic [G_W-1:0] LCD_G,
   output logic [B_W-1:0] LCD_B,
   output logic [7:0]     FRAME_COUNT,
   output logic [2:0]     ACTIVE_MODE
);

   localparam logic [XW-1:0] X_LIM  = XW'(H_ACTIVE - BOX_SIZE);
   localparam logic [YW-1:0] Y_LIM  = YW'(V_ACTIVE - BOX_SIZE);
   localparam logic [XW:0]   BOX_XS = (XW+1)'(BOX_SIZE);
   localparam logic [YW:0]   BOX_YS = (YW+1)'(BOX_SIZE);

   // stage 1
   logic           hs1_q, hs1_d;
   logic           vs1_q, vs1_d;
   logic           den1_q, den1_d;
   logic [2:0]     chk_q, chk_d;
   logic [2:0]     bar_q, bar_d;
   logic [R_W-1:0] grad_r_q, grad_r_d;
   logic [G_W-1:0] grad_g_q, grad_g_d;
   logic           hit_q, hit_d;
   logic           tick_q, tick_d;

   // frame state
   logic [7:0]     fc_q, fc_d;
   logic [2:0]     mode_q, mode_d;
   logic [XW-1:0]  box_x_q, box_x_d;
   logic [YW-1:0]  box_y_q, box_y_d;
   logic           dir_x_q, dir_x_d;
   logic           dir_y_q, dir_y_d;

   // stage 2
   logic           hs2_q, hs2_d;
   logic           vs2_q, vs2_d;
   logic           den2_q, den2_d;
   logic [R_W-1:0] r_q, r_d;
   logic [G_W-1:0] g_q, g_d;
   logic [B_W-1:0] b_q, b_d;

   logic [XW:0]    x_end;
   logic [YW:0]    y_end;

   always_comb begin
      hs1_d    = HSYNC_IN;
      vs1_d    = VSYNC_IN;
      den1_d   = DEN_IN;
      // vs1_q doubles as the VSYNC edge-detect register
      tick_d   = vs1_q & ~VSYNC_IN;
      chk_d    = {XPOS[CHECK_LOG2+2] ^ YPOS[CHECK_LOG2+2],
                  XPOS[CHECK_LOG2+1] ^ YPOS[CHECK_LOG2+1],
                  XPOS[CHECK_LOG2]   ^ YPOS[CHECK_LOG2]};
      bar_d    = XPOS[BAR_LOG2+2:BAR_LOG2];
      grad_r_d = R_W'(XPOS >> GRAD_SHIFT);
      grad_g_d = G_W'(YPOS >> GRAD_SHIFT);
      x_end    = {1'b0, box_x_q} + BOX_XS;
      y_end    = {1'b0, box_y_q} + BOX_YS;
      hit_d    = (XPOS >= box_x_q) && ({1'b0, XPOS} < x_end) &&
                 (YPOS >= box_y_q) && ({1'b0, YPOS} < y_end);
   end

   always_comb begin
      fc_d    = fc_q;
      mode_d  = mode_q;
      box_x_d = box_x_q;
      box_y_d = box_y_q;
      dir_x_d = dir_x_q;
      dir_y_d = dir_y_q;
      if (tick_q) begin
         fc_d   = fc_q + 8'd1;
         mode_d = MODE;
         if (!dir_x_q && box_x_q == X_LIM) begin
            dir_x_d = 1'b1;
            box_x_d = box_x_q - XW'(1);
         end else if (dir_x_q && box_x_q == '0) begin
            dir_x_d = 1'b0;
            box_x_d = XW'(1);
         end else begin
            box_x_d = dir_x_q ? box_x_q - XW'(1) : box_x_q + XW'(1);
         end
         if (!dir_y_q && box_y_q == Y_LIM) begin
            dir_y_d = 1'b1;
            box_y_d = box_y_q - YW'(1);
         end else if (dir_y_q && box_y_q == '0) begin
            dir_y_d = 1'b0;
            box_y_d = YW'(1);
         end else begin
            box_y_d = dir_y_q ? box_y_q - YW'(1) : box_y_q + YW'(1);
         end
      end
   end

   always_comb begin
      hs2_d  = hs1_q;
      vs2_d  = vs1_q;
      den2_d = den1_q;
      r_d    = '0;
      g_d    = '0;
      b_d    = '0;
      if (den1_q) begin
         unique case (mode_q)
            3'd0: begin
               r_d = {R_W{chk_q[0]}};
               g_d = {G_W{chk_q[1]}};
               b_d = {B_W{chk_q[2]}};
            end
            3'd1: begin
               r_d = {R_W{~bar_q[1]}};
               g_d = {G_W{~bar_q[2]}};
               b_d = {B_W{~bar_q[0]}};
            end
            3'd2: begin
               r_d = grad_r_q;
               g_d = grad_g_q;
               b_d = fc_q[7:8-B_W];
            end
            3'd3: begin
               r_d = {R_W{hit_q}};
               g_d = {G_W{hit_q}};
               b_d = {B_W{hit_q}};
            end
            3'd4: begin
               r_d = '1;
               g_d = '1;
               b_d = '1;
            end
            3'd5: r_d = '1;
            3'd6: g_d = '1;
            3'd7: b_d = '1;
         endcase
      end
   end

   always_ff @(posedge PIXEL_CLK) begin
      if (RESET) begin
         hs1_q    <= 1'b1;
         vs1_q    <= 1'b1;
         den1_q   <= 1'b0;
         chk_q    <= '0;
         bar_q    <= '0;
         grad_r_q <= '0;
         grad_g_q <= '0;
         hit_q    <= 1'b0;
         tick_q   <= 1'b0;
         fc_q     <= '0;
         mode_q   <= '0;
         box_x_q  <= '0;
         box_y_q  <= '0;
         dir_x_q  <= 1'b0;
         dir_y_q  <= 1'b0;
         hs2_q    <= 1'b1;
         vs2_q    <= 1'b1;
         den2_q   <= 1'b0;
         r_q      <= '0;
         g_q      <= '0;
         b_q      <= '0;
      end else begin
         hs1_q    <= hs1_d;
         vs1_q    <= vs1_d;
         den1_q   <= den1_d;
         chk_q    <= chk_d;
         bar_q    <= bar_d;
         grad_r_q <= grad_r_d;
         grad_g_q <= grad_g_d;
         hit_q    <= hit_d;
         tick_q   <= tick_d;
         fc_q     <= fc_d;
         mode_q   <= mode_d;
         box_x_q  <= box_x_d;
         box_y_q  <= box_y_d;
         dir_x_q  <= dir_x_d;
         dir_y_q  <= dir_y_d;
         hs2_q    <= hs2_d;
         vs2_q    <= vs2_d;
         den2_q   <= den2_d;
         r_q      <= r_d;
         g_q      <= g_d;
         b_q      <= b_d;
      end
   end

   assign HSYNC       = hs2_q;
   assign VSYNC       = vs2_q;
   assign DEN         = den2_q;
   assign LCD_R       = r_q;
   assign LCD_G       = g_q;
   assign LCD_B       = b_q;
   assign FRAME_COUNT = fc_q;
   assign ACTIVE_MODE = mode_q;

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Randomised frames against a behavioural model of lcd_pattern_gen.
module tb_lcd_pattern_gen;

   logic        PIXEL_CLK;
   logic        RESET;
   logic [2:0]  MODE;
   logic        HSYNC_IN, VSYNC_IN, DEN_IN;
   logic [10:0] XPOS, YPOS;
   logic        HSYNC, VSYNC, DEN;
   logic [4:0]  LCD_R;
   logic [5:0]  LCD_G;
   logic [4:0]  LCD_B;
   logic [7:0]  FRAME_COUNT;
   logic [2:0]  ACTIVE_MODE;

   lcd_pattern_gen dut (
      .PIXEL_CLK   (PIXEL_CLK),
      .RESET       (RESET),
      .MODE        (MODE),
      .HSYNC_IN    (HSYNC_IN),
      .VSYNC_IN    (VSYNC_IN),
      .DEN_IN      (DEN_IN),
      .XPOS        (XPOS),
      .YPOS        (YPOS),
      .HSYNC       (HSYNC),
      .VSYNC       (VSYNC),
      .DEN         (DEN),
      .LCD_R       (LCD_R),
      .LCD_G       (LCD_G),
      .LCD_B       (LCD_B),
      .FRAME_COUNT (FRAME_COUNT),
      .ACTIVE_MODE (ACTIVE_MODE)
   );

   initial PIXEL_CLK = 1'b0;
   always #5 PIXEL_CLK = ~PIXEL_CLK;

   int n_chk = 0;
   int n_err = 0;

   // model state: ticks seen since reset, mode in effect, one-cycle history
   int ticks_cur, ticks_old, mode_cur;
   bit prev_vs, prev2_vs;
   bit p_hs, p_vs, p_den;
   int p_x, p_y;

   int bar_r[8] = '{1, 1, 0, 0, 1, 1, 0, 0};
   int bar_g[8] = '{1, 1, 1, 1, 0, 0, 0, 0};
   int bar_b[8] = '{1, 0, 1, 0, 1, 0, 1, 0};
   int offs[4]  = '{-1, 0, 31, 32};

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // triangle wave: 0,1..lim..1,0,1..
   function automatic int tri_pos(input int t, input int lim);
      int p;
      p = t % (2 * lim);
      return (p <= lim) ? p : 2 * lim - p;
   endfunction

   function automatic logic [15:0] colour(input int x, input int y,
                                          input int m, input int fc,
                                          input int t);
      int r, g, b, i, bx, by;
      bit hit;
      r = 0; g = 0; b = 0;
      case (m)
         0: begin
            r = (((x >> 5) ^ (y >> 5)) & 1) ? 31 : 0;
            g = (((x >> 6) ^ (y >> 6)) & 1) ? 63 : 0;
            b = (((x >> 7) ^ (y >> 7)) & 1) ? 31 : 0;
         end
         1: begin
            i = (x >> 6) % 8;
            r = bar_r[i] * 31;
            g = bar_g[i] * 63;
            b = bar_b[i] * 31;
         end
         2: begin
            r = (x >> 3) % 32;
            g = (y >> 3) % 64;
            b = fc / 8;
         end
         3: begin
            bx  = tri_pos(t, 480 - 32);
            by  = tri_pos(t, 272 - 32);
            hit = x >= bx && x < bx + 32 && y >= by && y < by + 32;
            r = hit ? 31 : 0;
            g = hit ? 63 : 0;
            b = hit ? 31 : 0;
         end
         4: begin r = 31; g = 63; b = 31; end
         5: r = 31;
         6: g = 63;
         default: b = 31;
      endcase
      return {r[4:0], g[5:0], b[4:0]};
   endfunction

   task automatic step(input bit rst, input int md, input bit hs,
                       input bit vs, input bit den, input int x,
                       input int y);
      logic [2:0]  exp_sync;
      logic [15:0] exp_rgb;
      bit tick;
      RESET    = rst;
      MODE     = 3'(md);
      HSYNC_IN = hs;
      VSYNC_IN = vs;
      DEN_IN   = den;
      XPOS     = 11'(x);
      YPOS     = 11'(y);
      @(posedge PIXEL_CLK);
      #1;
      if (rst) begin
         ticks_cur = 0; ticks_old = 0; mode_cur = 0;
         prev_vs = 1; prev2_vs = 1;
         p_hs = 1; p_vs = 1; p_den = 0; p_x = 0; p_y = 0;
         exp_sync = 3'b110;
         exp_rgb  = '0;
      end else begin
         exp_sync = {p_hs, p_vs, p_den};
         exp_rgb  = p_den ? colour(p_x, p_y, mode_cur, ticks_cur % 256,
                                   ticks_old) : 16'h0;
         tick      = prev2_vs && !prev_vs;
         ticks_old = ticks_cur;
         if (tick) begin
            ticks_cur++;
            mode_cur = md;
         end
         prev2_vs = prev_vs;
         prev_vs  = vs;
         p_hs = hs; p_vs = vs; p_den = den;
         p_x = x & 2047; p_y = y & 2047;
      end
      check("sync", {HSYNC, VSYNC, DEN}, exp_sync);
      check("rgb", {LCD_R, LCD_G, LCD_B}, exp_rgb);
      check("frame_count", FRAME_COUNT, 32'(ticks_cur % 256));
      check("active_mode", ACTIVE_MODE, 32'(mode_cur));
   endtask

   // one short frame: VSYNC fall, gap, n pixels (MODE switches to md2)
   task automatic frame(input int md, input int md2, input int n,
                        input int fx, input int fy);
      int x, y;
      bit den;
      step(0, md, 1'($urandom_range(0, 1)), 0, 0, 0, 0);
      step(0, md, 1, 1, 0, 0, 0);
      for (int i = 0; i < n; i++) begin
         den = ($urandom_range(0, 7) != 0);
         if (i == 0 && fx >= 0) begin
            den = 1; x = fx; y = fy;
         end else if ($urandom_range(0, 3) == 0) begin
            x = $urandom_range(0, 2047);
            y = $urandom_range(0, 2047);
         end else begin
            x = (tri_pos(ticks_cur, 448) + offs[$urandom_range(0, 3)]) & 2047;
            y = (tri_pos(ticks_cur, 240) + offs[$urandom_range(0, 3)]) & 2047;
         end
         step(0, md2, 1'($urandom_range(0, 1)), 1, den, x, y);
      end
      step(0, md2, 1, 1, 0, 0, 0);
   endtask

   initial begin
      int md;
      for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 4, 1, 1, 0, 0, 0);
      frame(4, 4, 6, 0, 0);
      frame(0, 0, 4, 32, 0);
      frame(1, 1, 4, 130, 0);
      frame(0, 5, 6, 100, 40);
      frame(5, 5, 4, 7, 9);
      step(0, 2, 1, 1, 1, 200, 50);
      step(1, 2, 1, 0, 1, 201, 50);
      step(1, 2, 1, 0, 1, 202, 50);
      step(0, 2, 1, 0, 1, 203, 50);
      step(0, 2, 1, 1, 0, 0, 0);
      for (int f = 0; f < 1000; f++) begin
         md = ($urandom_range(0, 9) < 4) ? 3 : $urandom_range(0, 7);
         frame(md, $urandom_range(0, 7), $urandom_range(2, 6), -1, 0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule
